// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants, types and helpers shared by the fetch unit.
// Perf counters are compiled in only when FETCH_PERF_CNT_EN is defined.
package fetch_unit_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int FQ_DEPTH_DEF = 4;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // IF/ID register update selection, highest priority first
    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_HOLD,
        UPD_POP,
        UPD_BUBBLE
    } ifid_upd_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear, used for the instruction
// queue and for the PCs of requests still waiting on memory.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // a pop frees the head slot, so push on a full FIFO is fine then
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // pointer and occupancy next state; clear empties the FIFO
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // a push that cannot be accepted means the credit logic is broken
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst || clear_i)
        !(push_i && full_o && !pop_i)
    );

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage plus IF/ID register with a credit-limited fetch queue.
// Define FETCH_PERF_CNT_EN to add the bubble/flush/drop perf counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int             XLEN     = XLEN_DEF,
    parameter int             FQ_DEPTH = FQ_DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_stall,
    input  logic            flush,
    input  logic [XLEN-1:0] br_addr,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_drop_cnt
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [CW-1:0]     inflight_q;
    logic [CW-1:0]     inflight_d;
    logic [CW-1:0]     drop_q;
    logic [CW-1:0]     drop_d;
    logic              id_valid_q;
    logic              id_valid_d;
    logic [XLEN-1:0]   id_inst_q;
    logic [XLEN-1:0]   id_inst_d;
    logic [XLEN-1:0]   id_pc_q;
    logic [XLEN-1:0]   id_pc_d;

    logic              iq_push;
    logic              iq_pop;
    logic [2*XLEN-1:0] iq_rdata;
    logic [CW-1:0]     iq_count;
    logic              iq_full;
    logic              iq_empty;

    logic [XLEN-1:0]   pcq_rdata;
    logic [CW-1:0]     pcq_count;
    logic              pcq_full;
    logic              pcq_empty;

    logic [CW:0]       used;
    logic              req_valid;
    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_keep;
    ifid_upd_e         upd;

    // every slot is either in flight or buffered; never exceed the queue
    assign used      = {1'b0, inflight_q} + {1'b0, iq_count};
    assign req_valid = !rst && !flush && (used < (CW+1)'(FQ_DEPTH));
    assign req_fire  = req_valid && imem_req_ready;

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;

    // wrong-path responses and anything arriving during a flush are dropped
    assign rsp_drop = imem_rsp_valid && ((drop_q != '0) || flush);
    assign rsp_keep = imem_rsp_valid && !rsp_drop;

    assign iq_push = rsp_keep;
    assign iq_pop  = (upd == UPD_POP);

    // IF/ID update source: flush, then stall, then queue head or bubble
    always_comb begin
        if (flush) begin
            upd = UPD_FLUSH;
        end else if (load_stall) begin
            upd = UPD_HOLD;
        end else if (!iq_empty) begin
            upd = UPD_POP;
        end else begin
            upd = UPD_BUBBLE;
        end
    end

    // fetch bookkeeping next state: pc, outstanding and to-drop counts
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (flush) begin
            pc_d = br_addr;
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
        unique case ({req_fire, imem_rsp_valid})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        if (flush) begin
            drop_d = inflight_q - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    // IF/ID register next state
    always_comb begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        unique case (upd)
            UPD_FLUSH, UPD_BUBBLE: begin
                id_valid_d = 1'b0;
                id_inst_d  = XLEN'(INST_NOP);
            end
            UPD_POP: begin
                id_valid_d = 1'b1;
                id_pc_d    = iq_rdata[2*XLEN-1:XLEN];
                id_inst_d  = iq_rdata[XLEN-1:0];
            end
            default: begin
                id_valid_d = id_valid_q;
            end
        endcase
    end

    // fetch state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= XLEN'(INST_NOP);
            id_pc_q    <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_inst  = id_inst_q;
    assign id_pc    = id_pc_q;

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_iq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (iq_push),
        .wdata_i ({pcq_rdata, imem_rsp_data}),
        .pop_i   (iq_pop),
        .clear_i (flush),
        .rdata_o (iq_rdata),
        .count_o (iq_count),
        .full_o  (iq_full),
        .empty_o (iq_empty)
    );

    // request PCs survive a flush: their responses still have to retire
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_pcq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (imem_rsp_valid),
        .clear_i (1'b0),
        .rdata_o (pcq_rdata),
        .count_o (pcq_count),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

    a_pcq_tracks_inflight: assert property (
        @(posedge clk) disable iff (rst)
        pcq_count == inflight_q
    );

    a_rsp_has_pc: assert property (
        @(posedge clk) disable iff (rst)
        !(imem_rsp_valid && pcq_empty)
    );

    a_req_has_slot: assert property (
        @(posedge clk) disable iff (rst)
        !(req_fire && pcq_full)
    );

    a_iq_room: assert property (
        @(posedge clk) disable iff (rst || flush)
        !(rsp_keep && iq_full && !iq_pop)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_drop_q;

    // saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubble_q <= '0;
            perf_flush_q  <= '0;
            perf_drop_q   <= '0;
        end else begin
            if (upd == UPD_BUBBLE) begin
                perf_bubble_q <= sat_inc32(perf_bubble_q);
            end
            if (flush) begin
                perf_flush_q <= sat_inc32(perf_flush_q);
            end
            if (rsp_drop) begin
                perf_drop_q <= sat_inc32(perf_drop_q);
            end
        end
    end

    assign perf_bubble_cnt = perf_bubble_q;
    assign perf_flush_cnt  = perf_flush_q;
    assign perf_drop_cnt   = perf_drop_q;
`endif

endmodule
